// File: rtl/fetchq_pkg.sv
// rtl/fetchq_pkg.sv - shared types and constants for the instruction fetch queue
package fetchq_pkg;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// rtl/fetchq_fifo.sv - DEPTH-entry FIFO of fetched {pc, inst} pairs with flush
module fetchq_fifo
    import fetchq_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    fetch_entry_t  entries_q [DEPTH];

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // An empty queue presents zeros so the consumer never sees stale words.
    assign head_o  = empty_o ? '0 : entries_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && (!full_o || pop_i) && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) entries_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction prefetch FSM and queue; FETCHQ_BYPASS_EN enables ack-to-output bypass
module inst_fetch_queue
    import fetchq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    fetch_entry_t  head, push_data;
    logic [CW-1:0] count, count_next;
    logic          full, empty;
    logic          push, pop, ack_wait, bypass_hit;

    assign ack_wait = (state_q == WAIT) && mem_ack_i;

`ifdef FETCHQ_BYPASS_EN
    assign bypass_hit = ack_wait && empty && !redirect_i;
`else
    assign bypass_hit = 1'b0;
`endif

    assign inst_valid_o = !empty || bypass_hit;
    assign inst_o       = bypass_hit ? mem_rdata_i : head.inst;
    assign inst_pc_o    = bypass_hit ? fetch_pc_q  : head.pc;

    // Redirect squashes both ends of the queue in the same cycle.
    assign pop  = !empty && inst_ready_i && !redirect_i;
    assign push = ack_wait && !redirect_i && !(bypass_hit && inst_ready_i);

    assign push_data = '{pc: fetch_pc_q, inst: mem_rdata_i};

    assign mem_req_o  = (state_q == WAIT) || (state_q == DROP);
    assign mem_addr_o = addr_q;

    fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (!push && pop) count_next = count - 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect_i || !full) state_d = WAIT;
            end
            WAIT: begin
                if (redirect_i) begin
                    state_d = mem_ack_i ? WAIT : DROP;
                end else if (mem_ack_i) begin
                    fetch_pc_d = next_pc(fetch_pc_q);
                    state_d    = (count_next < CW'(DEPTH)) ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect_i) fetch_pc_d = redirect_pc_i;
        // A dropped request keeps its original address until the memory acks it.
        addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    ack_in_idle: assert property (@(posedge clk_i) disable iff (rst_i) !(state_q == IDLE && mem_ack_i));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
    import fetchq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge; the memory answers only a live request.
    task automatic cyc(input logic ack, input logic rdy, input logic redir = 1'b0,
                       input logic [31:0] tgt = 32'h0);
        @(negedge clk);
        redirect_i    = redir;
        redirect_pc_i = tgt;
        inst_ready_i  = rdy;
        mem_ack_i     = ack && mem_req_o;
        mem_rdata_i   = word(mem_addr_o);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   32'(mem_req_o), 32'd0);
        chk("rst_addr",  mem_addr_o, 32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst",  inst_o, 32'h0);
        chk("rst_pc",    inst_pc_o, 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_count", 32'(dut.u_fifo.count_o), 32'd0);
        rst_i = 1'b0;

        // Same-cycle memory, consumer always ready
        cyc(1'b1, 1'b1);
        chk("t1_req",  32'(mem_req_o), 32'd1);
        chk("t1_addr", mem_addr_o, 32'h0);
`ifndef FETCHQ_BYPASS_EN
        chk("t1_lat",  32'(inst_valid_o), 32'd0);
        cyc(1'b1, 1'b1);
`endif
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc(1'b1, 1'b1);
            chk("t1_valid", 32'(inst_valid_o), 32'd1);
            chk("t1_pc",    inst_pc_o, 32'(4 * i));
            chk("t1_inst",  inst_o, word(32'(4 * i)));
        end

        // Fill with ready low, then a single pop frees one slot
        do_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("t2_full_req",   32'(mem_req_o), 32'd0);
        chk("t2_full_count", 32'(dut.u_fifo.count_o), 32'd4);
        chk("t2_full_state", 32'(dut.state_q), 32'(IDLE));
        chk("t2_full_head",  inst_pc_o, 32'h0);
        cyc(1'b0, 1'b0);
        chk("t2_pop_req",   32'(mem_req_o), 32'd0);
        chk("t2_pop_count", 32'(dut.u_fifo.count_o), 32'd3);
        chk("t2_pop_head",  inst_pc_o, 32'h4);
        cyc(1'b1, 1'b0);
        chk("t2_new_req",  32'(mem_req_o), 32'd1);
        chk("t2_new_addr", mem_addr_o, 32'h10);
        cyc(1'b0, 1'b0);
        chk("t2_refill_count", 32'(dut.u_fifo.count_o), 32'd4);

        // Latency-3 memory, redirect during the WAIT for PC 8
        do_reset();
        rst_i = 1'b0;
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t3_addr8", mem_addr_o, 32'h8);
        cyc(1'b0, 1'b0, 1'b1, 32'h40);
        chk("t3_pre_count", 32'(dut.u_fifo.count_o), 32'd2);
        cyc(1'b0, 1'b0);
        chk("t3_drop_state", 32'(dut.state_q), 32'(DROP));
        chk("t3_drop_req",   32'(mem_req_o), 32'd1);
        chk("t3_drop_addr",  mem_addr_o, 32'h8);
        chk("t3_drop_valid", 32'(inst_valid_o), 32'd0);
        cyc(1'b1, 1'b0);
        chk("t3_stale_valid", 32'(inst_valid_o), 32'd0);
        cyc(1'b0, 1'b0);
        chk("t3_idle_state", 32'(dut.state_q), 32'(IDLE));
        chk("t3_idle_count", 32'(dut.u_fifo.count_o), 32'd0);
        cyc(1'b0, 1'b0);
        chk("t3_tgt_req",  32'(mem_req_o), 32'd1);
        chk("t3_tgt_addr", mem_addr_o, 32'h40);
        cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t3_out_valid", 32'(inst_valid_o), 32'd1);
        chk("t3_out_pc",    inst_pc_o, 32'h40);
        chk("t3_out_inst",  inst_o, word(32'h40));
        chk("t3_out_count", 32'(dut.u_fifo.count_o), 32'd1);

        // Redirect coincident with ack and pop
        do_reset();
        rst_i = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        cyc(1'b0, 1'b0);
        chk("t4_count", 32'(dut.u_fifo.count_o), 32'd0);
        chk("t4_valid", 32'(inst_valid_o), 32'd0);
        chk("t4_state", 32'(dut.state_q), 32'(WAIT));
        chk("t4_addr",  mem_addr_o, 32'h200);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t4_out_pc",    inst_pc_o, 32'h200);
        chk("t4_out_count", 32'(dut.u_fifo.count_o), 32'd1);

        // Fetch PC wraps past the top of the address space
        do_reset();
        rst_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        cyc(1'b1, 1'b0);
        chk("t5_addr0", mem_addr_o, 32'hFFFF_FFF8);
        cyc(1'b1, 1'b0);
        chk("t5_addr1", mem_addr_o, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0);
        chk("t5_addr2", mem_addr_o, 32'h0000_0000);
        cyc(1'b0, 1'b1);
        chk("t5_count", 32'(dut.u_fifo.count_o), 32'd3);
        chk("t5_pc0",   inst_pc_o, 32'hFFFF_FFF8);
        cyc(1'b0, 1'b1);
        chk("t5_pc1",   inst_pc_o, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b1);
        chk("t5_pc2",   inst_pc_o, 32'h0000_0000);
        chk("t5_inst2", inst_o, word(32'h0));
        cyc(1'b0, 1'b0);
        chk("t5_empty", 32'(inst_valid_o), 32'd0);
        chk("t5_next",  mem_addr_o, 32'h4);

        // Ack-to-output latency on an empty queue
        do_reset();
        rst_i = 1'b0;
        cyc(1'b1, 1'b1);
`ifdef FETCHQ_BYPASS_EN
        chk("t6_byp_valid", 32'(inst_valid_o), 32'd1);
        chk("t6_byp_pc",    inst_pc_o, 32'h0);
        chk("t6_byp_inst",  inst_o, word(32'h0));
        cyc(1'b0, 1'b0);
        chk("t6_byp_count", 32'(dut.u_fifo.count_o), 32'd0);
        chk("t6_byp_after", 32'(inst_valid_o), 32'd0);
`else
        chk("t6_ack_valid", 32'(inst_valid_o), 32'd0);
        cyc(1'b0, 1'b0);
        chk("t6_next_valid", 32'(inst_valid_o), 32'd1);
        chk("t6_next_pc",    inst_pc_o, 32'h0);
        chk("t6_next_count", 32'(dut.u_fifo.count_o), 32'd1);
`endif
        chk("t6_addr", mem_addr_o, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch queue between the instruction-memory port and the IF/ID pipeline register. It issues sequential fetch requests to a backing instruction memory with variable latency, and buffers returned instructions with their PCs in a small FIFO. It presents them to IF/ID under a valid/ready handshake; ready is the hazard unit's IF/ID write enable. A taken branch resolved in ID flushes the queue and redirects fetch to the branch target.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- redirect_i  in  1  taken branch (branch AND equal) from ID; flush and redirect.
- redirect_pc_i  in  32  branch target.
- mem_req_o  out  1  fetch request valid.
- mem_addr_o  out  32  fetch address; stable while mem_req_o=1 and not acknowledged.
- mem_ack_i  in  1  memory response valid; completes the current request.
- mem_rdata_i  in  32  instruction word, valid with mem_ack_i.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  32  head instruction.
- inst_pc_o  out  32  head PC.
- inst_ready_i  in  1  consumer accepts head (IF/ID write enable).

## Operation
- Reset values: state IDLE; fetch_pc=RESET_PC; count=0; rd/wr pointers=0. Outputs: mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0.
- FSM states:
  - IDLE: no request outstanding. With no redirect and count<DEPTH, go to WAIT.
  - WAIT: mem_req_o=1, mem_addr_o=fetch_pc. On mem_ack_i, push {fetch_pc, mem_rdata_i} and set fetch_pc+=4. Then stay in WAIT if count_after_push<DEPTH, otherwise go to IDLE.
  - DROP: mem_req_o=1 with the stale address held. On mem_ack_i, discard the data and go to IDLE.
- mem_req_o = (state==WAIT || state==DROP).
- At most one request is outstanding. A request is issued only when count<DEPTH, and pops only free slots, so a push never overflows.
- Pop: inst_valid_o && inst_ready_i && !redirect_i. It advances rd pointer, count-1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect, any state: the queue empties next cycle (count=0, pointers reset to 0) and fetch_pc=redirect_pc_i.
  - IDLE: next state WAIT if no other condition blocks it.
  - WAIT without mem_ack_i: go to DROP; the address is held until ack, which is the handshake rule.
  - WAIT with mem_ack_i in the same cycle: the data is not pushed; next state WAIT at the target.
  - DROP: stay in DROP; ack goes to IDLE.
  - Redirect takes priority over pop and push in the same cycle.
- Redirect while mem_ack_i arrives in DROP: fetch_pc takes the new target and the state goes to IDLE.
- fetch_pc arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- mem_ack_i in IDLE is ignored. A protocol assertion flags it.

## Timing
- First mem_req_o=1 in the first cycle after rst_i deasserts.
- Without bypass, ack in cycle N makes inst_valid_o=1 in cycle N+1.
- With a same-cycle-ack memory, sustained throughput is 1 instruction per cycle.
- A redirect in cycle N gives inst_valid_o=0 in N+1. The earliest target request is in N+1, or after the stale ack when in DROP.
- Reset asserted mid-request drops the request immediately; the memory is expected to reset too.

## Configuration
- FETCHQ_BYPASS_EN defined: when the queue is empty and mem_ack_i=1 in WAIT without redirect, the response is driven combinationally on inst_o/inst_pc_o with inst_valid_o=1 in the same cycle. If inst_ready_i=1, it is not written into the queue; otherwise it is pushed. Latency is 0 cycles after ack.
- Not defined: all outputs come from the registered queue head, with 1-cycle latency after ack.

## Structure
- Package fetchq_pkg:
  - fetch_entry_t {pc[31:0], inst[31:0]}
  - state enum {IDLE, WAIT, DROP}
  - INST_BYTES=4
  - default RESET_PC
- Sub-module fetchq_fifo: DEPTH-entry storage of fetch_entry_t with push, pop, flush, count, full and empty. The top holds the FSM, fetch_pc and the handshake.

## Test plan
- Reset, then memory acks every request in the same cycle, ready=1. Expect PCs 0,4,8,12 on consecutive cycles with inst_o matching memory contents.
- ready=0, DEPTH=4. After 4 pushes mem_req_o=0 and count=4. Raising ready for 1 cycle gives one pop, then a new request at PC 16.
- Memory latency 3. Assert redirect_i with target 0x40 in the 2nd cycle of the WAIT for PC 8. Expect DROP, the stale ack discarded, then a request at 0x40 and first output PC 0x40.
- Redirect coincident with mem_ack_i and with a pop. Expect no push, no pop, count=0 next cycle, and the next request at the target.
- Start fetch at 0xFFFF_FFF8. Expect PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCHQ_BYPASS_EN: empty queue, ack with ready=1. Expect inst_valid_o=1 in the ack cycle and count stays 0.
